button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions the raw push-button on the CQTV demo board before it reaches the LED pattern logic. Synchronises the asynchronous pin into `clk50mhz`, rejects contact bounce with a consecutive-sample counter, and presents a clean active-high level plus single-cycle press, release and long-press pulses and a press-toggled flag. Sits between the board pin and any mode/pattern selector that consumes `button`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a change (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_PRESS_CYCLES`, default 50_000_000: cycles held after the press edge before `long_press` fires (1 s); must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 = pin reads 0 when pressed.
- `clk50mhz`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `button_raw`  in  1  unsynchronised board pin.
- `button`  out  1  debounced level, 1 = pressed.
- `press`  out  1  one-cycle pulse on accepted press.
- `release`  out  1  one-cycle pulse on accepted release.
- `long_press`  out  1  one-cycle pulse, at most once per press.
- `toggle`  out  1  flips on every `press`.

## Operation
- Input path: `button_raw` XOR `ACTIVE_LOW` → 2-flop synchroniser → `sync` (1 = pressed). Synchroniser flops reset to the released level.
- FSM states: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING. Reset → RELEASED.
- RELEASED: `sync`=1 → PRESS_PENDING, debounce count := 1.
- PRESS_PENDING: `sync`=1 → count+1; when count reaches `DEBOUNCE_CYCLES` → PRESSED, `button`:=1, `press` and `toggle` flip asserted that edge. `sync`=0 → RELEASED, count := 0 (any bounce restarts).
- PRESSED: `sync`=0 → RELEASE_PENDING, count := 1.
- RELEASE_PENDING: symmetric; acceptance → RELEASED, `button`:=0, `release` pulse. `sync`=1 → PRESSED, count := 0.
- Hold counter: cleared on the `press` edge, increments every cycle in PRESSED or RELEASE_PENDING, saturates at `LONG_PRESS_CYCLES`; `long_press` asserts for the single cycle the counter reaches `LONG_PRESS_CYCLES`. No repeat until a new press.
- Release accepted before the hold counter reaches the limit → no `long_press`.
- Counter widths: `$clog2(N+1)` for each limit; no wrap is reachable (saturating/cleared).
- All outputs registered; no combinational path from `button_raw`.

## Timing
- Reset values: `button`=0, `press`=0, `release`=0, `long_press`=0, `toggle`=0, state RELEASED, all counters 0.
- Latency: raw pin settles before edge k → `sync` valid after edge k+1 → `button`/`press` change on edge k+1+`DEBOUNCE_CYCLES`.
- `long_press` asserted exactly `LONG_PRESS_CYCLES` edges after the edge that asserted `press`.
- `press`, `release`, `long_press` never high for two consecutive cycles; `press` and `release` never high together. `long_press` may coincide with the cycle a release goes pending but never with `release`.
- Reset mid-press: all outputs drop asynchronously; a button still held after reset deassertion produces a fresh `press` after 2+`DEBOUNCE_CYCLES` edges.

## Structure
- State encodings (2-bit) and default limit constants live in the shared CQTV defines include so downstream mode logic can reference them.
- One sub-module: `sync_2ff` (parameterised reset value), reused for other board inputs.
- Bench uses `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=32, `ACTIVE_LOW`=1.

## Test plan
- Clean press: pin 1→0 held 40 cycles → `press` one cycle on edge 10 after change, `button`=1, `toggle`=1; `long_press` 32 edges after `press`.
- Bounce: pin toggles every 3 cycles for 30 cycles, then stays 0 → no pulse during bounce, single `press` 10 edges after final settle.
- Short glitch: pin low for 7 cycles only → no `press`, `button` stays 0.
- Short press: held 20 cycles then released clean → `press`, then `release` 10 edges after pin rises, no `long_press`, `toggle`=1.
- Two full presses → `toggle` returns to 0; `long_press` fires once per press only.
- Reset asserted while `button`=1 → all outputs 0 immediately; pin still low → `press` 10 edges after reset release.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared CQTV push-button definitions: debouncer state encoding and default
// limits, visible to downstream mode/pattern logic.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED        = 2'd0,
    ST_PRESS_PENDING   = 2'd1,
    ST_PRESSED         = 2'd2,
    ST_RELEASE_PENDING = 2'd3
  } db_state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;   // 20 ms at 50 MHz
  localparam int DEF_LONG_PRESS_CYCLES = 50_000_000;  // 1 s at 50 MHz

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; reset value chosen per input.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk50mhz,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, debounce by consecutive-sample count,
// then emit a clean level, press/release/long-press pulses and a press toggle.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk50mhz,
  input  logic reset,
  input  logic button_raw,
  output logic button,
  output logic press,
  output logic release_pulse,  // 'release' is a reserved word
  output logic long_press,
  output logic toggle
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

  db_state_e     state;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          sync;
  logic          rel_accept;
  logic          hold_run;

  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk50mhz (clk50mhz),
    .reset    (reset),
    .d        (button_raw ^ ACTIVE_LOW),
    .q        (sync)
  );

  // The hold counter stops on the release-acceptance edge so long_press can
  // never coincide with release_pulse.
  assign rel_accept = (state == ST_RELEASE_PENDING) && !sync && (db_cnt == DB_LAST);
  assign hold_run   = ((state == ST_PRESSED) || (state == ST_RELEASE_PENDING)) &&
                      !rel_accept && (hold_cnt != HOLD_MAX);

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      state         <= ST_RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      button        <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;

      unique case (state)
        ST_RELEASED:
          if (sync) begin
            state  <= ST_PRESS_PENDING;
            db_cnt <= DW'(1);
          end
        ST_PRESS_PENDING:
          if (!sync) begin
            state  <= ST_RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state    <= ST_PRESSED;
            db_cnt   <= '0;
            hold_cnt <= '0;
            button   <= 1'b1;
            press    <= 1'b1;
            toggle   <= ~toggle;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        ST_PRESSED:
          if (!sync) begin
            state  <= ST_RELEASE_PENDING;
            db_cnt <= DW'(1);
          end
        ST_RELEASE_PENDING:
          if (sync) begin
            state  <= ST_PRESSED;
            db_cnt <= '0;
          end else if (rel_accept) begin
            state         <= ST_RELEASED;
            db_cnt        <= '0;
            button        <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        default: state <= ST_RELEASED;
      endcase

      if (hold_run) begin
        hold_cnt   <= hold_cnt + HW'(1);
        long_press <= (hold_cnt == HOLD_LAST);
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed stimulus against a run-length reference model of the debouncer.
module tb_button_debouncer;

  localparam int DB = 8;
  localparam int LP = 32;

  logic clk50mhz   = 1'b0;
  logic reset      = 1'b1;
  logic button_raw = 1'b1;
  logic button, press, release_pulse, long_press, toggle;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: pin history two edges deep, accepted level, run length
  bit m_d1, m_d2, m_lvl, m_tgl;
  int m_streak, m_press_at;

  int obs_press_at, obs_rel_at, obs_long_at, first;

  button_debouncer #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clk50mhz      (clk50mhz),
    .reset         (reset),
    .button_raw    (button_raw),
    .button        (button),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .toggle        (toggle)
  );

  always #5 clk50mhz = ~clk50mhz;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = 1'b0; m_d2 = 1'b0; m_lvl = 1'b0; m_tgl = 1'b0;
    m_streak = 0; m_press_at = -100000;
  endtask

  function automatic int outs();
    return {27'b0, button, press, release_pulse, long_press, toggle};
  endfunction

  task automatic tick(input bit pin);
    bit s, e_press, e_rel, e_long;
    @(negedge clk50mhz) button_raw = pin;
    @(posedge clk50mhz) cyc++;
    s = m_d2; m_d2 = m_d1; m_d1 = ~pin;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (s != m_lvl) m_streak++; else m_streak = 0;
    if (m_streak == DB) begin
      m_lvl = s; m_streak = 0;
      if (m_lvl) begin e_press = 1'b1; m_tgl = ~m_tgl; m_press_at = cyc; end
      else e_rel = 1'b1;
    end
    if (m_lvl && cyc == m_press_at + LP) e_long = 1'b1;
    #1;
    if (press)         obs_press_at = cyc;
    if (release_pulse) obs_rel_at   = cyc;
    if (long_press)    obs_long_at  = cyc;
    chk("outs", outs(), {27'b0, m_lvl, e_press, e_rel, e_long, m_tgl});
  endtask

  task automatic hold(input bit pin, input int n);
    repeat (n) tick(pin);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk50mhz);
    #1 chk("rst_init", outs(), 0);
    reset = 1'b0;
    hold(1'b1, 5);

    // clean press, held long enough for long_press
    first = cyc + 1; obs_press_at = -1; obs_long_at = -1;
    hold(1'b0, 50);
    chk("press_lat", obs_press_at - first + 1, 10);
    chk("long_lat", obs_long_at - obs_press_at, LP);
    chk("toggle1", toggle, 1);
    hold(1'b1, 20);

    // bounce every 3 cycles, then settle pressed
    obs_press_at = -1;
    for (int i = 0; i < 10; i++) hold(bit'(i % 2), 3);
    chk("bounce_quiet", obs_press_at, -1);
    first = cyc + 1;
    hold(1'b0, 20);
    chk("bounce_lat", obs_press_at - first + 1, 10);
    hold(1'b1, 20);
    chk("toggle2", toggle, 0);

    // short glitch
    obs_press_at = -1;
    hold(1'b0, 7);
    hold(1'b1, 20);
    chk("glitch_press", obs_press_at, -1);
    chk("glitch_btn", button, 0);

    // short press: release but no long_press
    obs_long_at = -1; obs_rel_at = -1;
    hold(1'b0, 20);
    first = cyc + 1;
    hold(1'b1, 20);
    chk("rel_lat", obs_rel_at - first + 1, 10);
    chk("short_no_long", obs_long_at, -1);
    chk("toggle3", toggle, 1);

    // random segments
    for (int i = 0; i < 40; i++) hold(bit'($urandom_range(0, 1)), $urandom_range(1, 45));
    hold(1'b1, 20);

    // reset while pressed, pin still held
    hold(1'b0, 15);
    chk("pre_rst_btn", button, 1);
    #1 reset = 1'b1;
    #1 chk("rst_async", outs(), 0);
    #1 reset = 1'b0;
    model_reset();
    first = cyc + 1; obs_press_at = -1;
    hold(1'b0, 15);
    chk("rst_press_lat", obs_press_at - first + 1, 10);
    hold(1'b1, 20);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
